// File: rtl/nibble_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nibble_bus_pkg
// Purpose  : Shared widths, I/O page map and decode helper for the responder.
// Revision : 1.0
// ============================================================================
package nibble_bus_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 4;

  localparam logic [ADDR_W-1:0] IO_BASE = 12'hFF0;

  localparam logic [3:0] OFF_CNT0   = 4'h0;
  localparam logic [3:0] OFF_CNT1   = 4'h1;
  localparam logic [3:0] OFF_CNT2   = 4'h2;
  localparam logic [3:0] OFF_CMP0   = 4'h4;
  localparam logic [3:0] OFF_CMP1   = 4'h5;
  localparam logic [3:0] OFF_CMP2   = 4'h6;
  localparam logic [3:0] OFF_STATUS = 4'h8;
  localparam logic [3:0] OFF_GPIO   = 4'hA;
  localparam logic [3:0] OFF_ID     = 4'hF;

  localparam int STATUS_MATCH_BIT = 0;
  localparam int STATUS_IRQEN_BIT = 1;

  typedef enum logic [1:0] {
    TGT_RAM  = 2'd0,
    TGT_IO   = 2'd1,
    TGT_NONE = 2'd2
  } target_e;

  function automatic target_e decode_target(input logic [ADDR_W-1:0] addr,
                                            input int ram_depth);
    if ({20'd0, addr} < 32'(ram_depth)) begin
      return TGT_RAM;
    end else if (addr[ADDR_W-1:4] == IO_BASE[ADDR_W-1:4]) begin
      return TGT_IO;
    end else begin
      return TGT_NONE;
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/nibble_bus_responder_timer.sv
`default_nettype none
// ============================================================================
// Module   : nibble_tick_timer
// Purpose  : Prescaled 12-bit tick counter with compare, match flag, irq
//            enable and high-byte snapshot for the I/O page.
// Revision : 1.0
// ============================================================================
module nibble_tick_timer
  import nibble_bus_pkg::*;
#(
  parameter int TICK_DIV = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_cnt0_rd,
  input  logic [2:0]        i_cmp_we,
  input  logic              i_status_we,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_cnt0_rdata,
  output logic [DATA_W-1:0] o_cnt1_rdata,
  output logic [DATA_W-1:0] o_cnt2_rdata,
  output logic [DATA_W-1:0] o_cmp0_rdata,
  output logic [DATA_W-1:0] o_cmp1_rdata,
  output logic [DATA_W-1:0] o_cmp2_rdata,
  output logic [DATA_W-1:0] o_status_rdata,
  output logic              o_irq
);

  localparam int               PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0]  r_presc;
  logic [ADDR_W-1:0] r_count;
  logic [ADDR_W-1:0] r_cmp;
  logic [7:0]        r_snap;
  logic              r_match;
  logic              r_irq_en;

  logic              w_tick;
  logic [ADDR_W-1:0] w_count_inc;
  logic              w_match_set;
  logic              w_match_clr;

  assign w_tick      = (r_presc == PRE_LAST);
  assign w_count_inc = r_count + 12'd1;
  // Compare against the counter value the tick produces; a CMP write alone never matches.
  assign w_match_set = w_tick && (w_count_inc == r_cmp);
  assign w_match_clr = i_status_we && i_wdata[STATUS_MATCH_BIT];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc  <= '0;
      r_count  <= '0;
      r_cmp    <= '0;
      r_snap   <= '0;
      r_match  <= 1'b0;
      r_irq_en <= 1'b0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + PRE_W'(1);
      if (w_tick) begin
        r_count <= w_count_inc;
      end
      // Snapshot takes the pre-increment high byte so CNT0..CNT2 stay coherent.
      if (i_cnt0_rd) begin
        r_snap <= r_count[ADDR_W-1:4];
      end
      for (int i = 0; i < 3; i++) begin
        if (i_cmp_we[i]) begin
          r_cmp[i*DATA_W +: DATA_W] <= i_wdata;
        end
      end
      if (i_status_we) begin
        r_irq_en <= i_wdata[STATUS_IRQEN_BIT];
      end
      if (w_match_set) begin
        r_match <= 1'b1;
      end else if (w_match_clr) begin
        r_match <= 1'b0;
      end
    end
  end

  assign o_cnt0_rdata   = r_count[3:0];
  assign o_cnt1_rdata   = r_snap[3:0];
  assign o_cnt2_rdata   = r_snap[7:4];
  assign o_cmp0_rdata   = r_cmp[3:0];
  assign o_cmp1_rdata   = r_cmp[7:4];
  assign o_cmp2_rdata   = r_cmp[11:8];
  assign o_status_rdata = {2'b00, r_irq_en, r_match};
  assign o_irq          = r_match & r_irq_en;

endmodule
`default_nettype wire

// File: rtl/nibble_bus_responder.sv
`default_nettype none
// ============================================================================
// Module   : nibble_bus_responder
// Purpose  : CPU bus responder: address decode, nibble RAM, I/O page
//            (timer, GPIO, ID) and the registered read-data path.
// Revision : 1.0
// ============================================================================
module nibble_bus_responder
  import nibble_bus_pkg::*;
#(
  parameter int              RAM_DEPTH = 64,
  parameter int              TICK_DIV  = 1,
  parameter logic [DATA_W-1:0] ID_VALUE  = 4'hA
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_bus_addr,
  input  logic              i_bus_data_rw,
  input  logic [DATA_W-1:0] i_bus_data_in,
  output logic [DATA_W-1:0] o_bus_data_out,
  output logic [DATA_W-1:0] o_gpio_out,
  output logic              o_irq
);

  localparam int RAM_AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

  logic [DATA_W-1:0] r_ram [RAM_DEPTH];
  logic [DATA_W-1:0] r_gpio;
  logic [DATA_W-1:0] r_rdata;

  target_e           w_target;
  logic [3:0]        w_off;
  logic              w_io_rd;
  logic              w_io_wr;
  logic [RAM_AW-1:0] w_ram_idx;
  logic [DATA_W-1:0] w_rdata;

  logic [DATA_W-1:0] w_cnt0_rdata;
  logic [DATA_W-1:0] w_cnt1_rdata;
  logic [DATA_W-1:0] w_cnt2_rdata;
  logic [DATA_W-1:0] w_cmp0_rdata;
  logic [DATA_W-1:0] w_cmp1_rdata;
  logic [DATA_W-1:0] w_cmp2_rdata;
  logic [DATA_W-1:0] w_status_rdata;

  assign w_target  = decode_target(i_bus_addr, RAM_DEPTH);
  assign w_off     = i_bus_addr[3:0];
  assign w_io_rd   = (w_target == TGT_IO) && !i_bus_data_rw;
  assign w_io_wr   = (w_target == TGT_IO) &&  i_bus_data_rw;
  assign w_ram_idx = i_bus_addr[RAM_AW-1:0];

  nibble_tick_timer #(
    .TICK_DIV (TICK_DIV)
  ) u_timer (
    .clk            (clk),
    .rst            (rst),
    .i_cnt0_rd      (w_io_rd && (w_off == OFF_CNT0)),
    .i_cmp_we       ({w_io_wr && (w_off == OFF_CMP2),
                      w_io_wr && (w_off == OFF_CMP1),
                      w_io_wr && (w_off == OFF_CMP0)}),
    .i_status_we    (w_io_wr && (w_off == OFF_STATUS)),
    .i_wdata        (i_bus_data_in),
    .o_cnt0_rdata   (w_cnt0_rdata),
    .o_cnt1_rdata   (w_cnt1_rdata),
    .o_cnt2_rdata   (w_cnt2_rdata),
    .o_cmp0_rdata   (w_cmp0_rdata),
    .o_cmp1_rdata   (w_cmp1_rdata),
    .o_cmp2_rdata   (w_cmp2_rdata),
    .o_status_rdata (w_status_rdata),
    .o_irq          (o_irq)
  );

  // RAM contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (i_bus_data_rw && (w_target == TGT_RAM)) begin
      r_ram[w_ram_idx] <= i_bus_data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_gpio <= '0;
    end else if (w_io_wr && (w_off == OFF_GPIO)) begin
      r_gpio <= i_bus_data_in;
    end
  end

  always_comb begin
    w_rdata = '0;
    unique case (w_target)
      TGT_RAM: w_rdata = r_ram[w_ram_idx];
      TGT_IO: begin
        case (w_off)
          OFF_CNT0:   w_rdata = w_cnt0_rdata;
          OFF_CNT1:   w_rdata = w_cnt1_rdata;
          OFF_CNT2:   w_rdata = w_cnt2_rdata;
          OFF_CMP0:   w_rdata = w_cmp0_rdata;
          OFF_CMP1:   w_rdata = w_cmp1_rdata;
          OFF_CMP2:   w_rdata = w_cmp2_rdata;
          OFF_STATUS: w_rdata = w_status_rdata;
          OFF_GPIO:   w_rdata = r_gpio;
          OFF_ID:     w_rdata = ID_VALUE;
          default:    w_rdata = '0;
        endcase
      end
      default: w_rdata = '0;
    endcase
  end

  // Write cycles leave the last read value on the bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (!i_bus_data_rw) begin
      r_rdata <= w_rdata;
    end
  end

  assign o_bus_data_out = r_rdata;
  assign o_gpio_out     = r_gpio;

endmodule
`default_nettype wire
